// File: rtl/alu_pkg.sv
// Shared width and function-code definitions for the 4-bit execute-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_W = 4;

  // Function code packed as {S2,S1,S0}
  typedef enum logic [2:0] {
    ARITH_A    = 3'b000,
    ARITH_ADD  = 3'b001,
    ARITH_SUBB = 3'b010,
    ARITH_DEC  = 3'b011,
    LOG_AND    = 3'b100,
    LOG_OR     = 3'b101,
    LOG_XOR    = 3'b110,
    LOG_NOT    = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_arith_unit.sv
// Combinational adder path: sum = A + Y + Cin with Y chosen by S1S0.
// Overflow output exists only when ALU_FLAGS_EN is defined.
module alu_arith_unit
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s1,
  input  logic         s0,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef ALU_FLAGS_EN
  ,
  output logic         ovf
`endif
);

  logic [W-1:0] y;
  logic [W:0]   sum_full;

  // Second adder operand: zero, B, ~B or all ones
  always_comb begin
    y = '0;
    unique case ({s1, s0})
      2'b00:   y = '0;
      2'b01:   y = b;
      2'b10:   y = ~b;
      default: y = '1;
    endcase
  end

  assign sum_full = {1'b0, a} + {1'b0, y} + (W+1)'(cin);
  assign sum      = sum_full[W-1:0];
  assign cout     = sum_full[W];

`ifdef ALU_FLAGS_EN
  // Carry into the MSB recovered from the MSB sum bit, XORed with carry out
  assign ovf = (a[W-1] ^ y[W-1] ^ sum_full[W-1]) ^ sum_full[W];
`endif

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: adder path when S2=0, bitwise logic when S2=1.
// Optional Z/N/V flag outputs are built when ALU_FLAGS_EN is defined.
module alu_4bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             Cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             V
`endif
);

  alu_op_e          op_c;
  logic [WIDTH-1:0] arith_sum_c;
  logic             arith_cout_c;
  logic [WIDTH-1:0] result_c;
  logic             cout_c;
`ifdef ALU_FLAGS_EN
  logic             arith_ovf_c;
`endif

  alu_arith_unit #(.W(WIDTH)) u_arith (
    .a    (A),
    .b    (B),
    .s1   (S1),
    .s0   (S0),
    .cin  (Cin),
    .sum  (arith_sum_c),
    .cout (arith_cout_c)
`ifdef ALU_FLAGS_EN
    ,
    .ovf  (arith_ovf_c)
`endif
  );

  assign op_c = alu_op_e'({S2, S1, S0});

  // Result mux: logic ops never produce a carry
  always_comb begin
    result_c = '0;
    cout_c   = 1'b0;
    unique case (op_c)
      LOG_AND: result_c = A & B;
      LOG_OR:  result_c = A | B;
      LOG_XOR: result_c = A ^ B;
      LOG_NOT: result_c = ~A;
      default: begin
        result_c = arith_sum_c;
        cout_c   = arith_cout_c;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      G    <= '0;
      Cout <= 1'b0;
    end else begin
      G    <= result_c;
      Cout <= cout_c;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Z <= 1'b0;
      N <= 1'b0;
      V <= 1'b0;
    end else begin
      Z <= (result_c == '0);
      N <= result_c[WIDTH-1];
      V <= S2 ? 1'b0 : arith_ovf_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Directed-vector bench for alu_4bit; flag checks compile in with ALU_FLAGS_EN.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       S2, S1, S0, Cin;
  logic [3:0] A, B;
  logic [3:0] G;
  logic       Cout;
`ifdef ALU_FLAGS_EN
  logic       Z, N, V;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .S2    (S2),
    .S1    (S1),
    .S0    (S0),
    .Cin   (Cin),
    .A     (A),
    .B     (B),
    .G     (G),
    .Cout  (Cout)
`ifdef ALU_FLAGS_EN
    ,
    .Z     (Z),
    .N     (N),
    .V     (V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic       cout;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one operation, clock it in, sample 1 time unit after the edge
  task automatic step(input logic [2:0] op, input logic cin,
                      input logic [3:0] a, input logic [3:0] b);
    {S2, S1, S0} = op;
    Cin = cin;
    A   = a;
    B   = b;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Arithmetic sweep A=1111 B=0001
    vecs.push_back('{3'b000, 1'b0, 4'hF, 4'h1, 4'hF, 1'b0});
    vecs.push_back('{3'b000, 1'b1, 4'hF, 4'h1, 4'h0, 1'b1});
    vecs.push_back('{3'b001, 1'b0, 4'hF, 4'h1, 4'h0, 1'b1});
    vecs.push_back('{3'b001, 1'b1, 4'hF, 4'h1, 4'h1, 1'b1});
    vecs.push_back('{3'b010, 1'b0, 4'hF, 4'h1, 4'hD, 1'b1});
    vecs.push_back('{3'b010, 1'b1, 4'hF, 4'h1, 4'hE, 1'b1});
    vecs.push_back('{3'b011, 1'b0, 4'hF, 4'h1, 4'hE, 1'b1});
    vecs.push_back('{3'b011, 1'b1, 4'hF, 4'h1, 4'hF, 1'b1});
    // Logic sweep, Cin both values
    for (int c = 0; c < 2; c++) begin
      vecs.push_back('{3'b100, 1'(c), 4'hF, 4'h1, 4'h1, 1'b0});
      vecs.push_back('{3'b101, 1'(c), 4'hF, 4'h1, 4'hF, 1'b0});
      vecs.push_back('{3'b110, 1'(c), 4'hF, 4'h1, 4'hE, 1'b0});
      vecs.push_back('{3'b111, 1'(c), 4'hF, 4'h1, 4'h0, 1'b0});
    end
    // Subtract borrow / no borrow
    vecs.push_back('{3'b010, 1'b1, 4'h3, 4'h5, 4'hE, 1'b0});
    vecs.push_back('{3'b010, 1'b1, 4'h5, 4'h3, 4'h2, 1'b1});
    // Back-to-back mixed operands
    vecs.push_back('{3'b001, 1'b0, 4'h6, 4'h7, 4'hD, 1'b0});
    vecs.push_back('{3'b101, 1'b0, 4'hA, 4'h5, 4'hF, 1'b0});
    vecs.push_back('{3'b000, 1'b1, 4'h7, 4'h0, 4'h8, 1'b0});
    vecs.push_back('{3'b100, 1'b1, 4'hC, 4'hA, 4'h8, 1'b0});
    vecs.push_back('{3'b011, 1'b0, 4'h0, 4'h9, 4'hF, 1'b0});
    vecs.push_back('{3'b110, 1'b0, 4'h9, 4'h3, 4'hA, 1'b0});
    vecs.push_back('{3'b001, 1'b1, 4'h8, 4'h8, 4'h1, 1'b1});

    // Reset held across two edges with an add pending
    rst_n = 1'b0;
    step(3'b001, 1'b0, 4'hF, 4'h1);
    step(3'b001, 1'b0, 4'hF, 4'h1);
    check("reset_g", 32'(G), 32'h0);
    check("reset_cout", 32'(Cout), 32'h1 ^ 32'h1);
    rst_n = 1'b1;
    step(3'b001, 1'b0, 4'hF, 4'h1);
    check("post_reset_g", 32'(G), 32'h0);
    check("post_reset_cout", 32'(Cout), 32'h1);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_g", i), 32'(G), 32'(vecs[i].g));
      check($sformatf("v%0d_cout", i), 32'(Cout), 32'(vecs[i].cout));
    end

    // Inputs changing between edges leave the registered outputs alone
    {S2, S1, S0} = 3'b111;
    A = 4'h0;
    #3;
    check("hold_g", 32'(G), 32'h1);
    check("hold_cout", 32'(Cout), 32'h1);

    // Mid-stream reset
    rst_n = 1'b0;
    step(3'b001, 1'b1, 4'hF, 4'hF);
    check("mid_reset_g", 32'(G), 32'h0);
    check("mid_reset_cout", 32'(Cout), 32'h0);
    rst_n = 1'b1;
    step(3'b001, 1'b1, 4'hF, 4'hF);
    check("after_mid_reset_g", 32'(G), 32'hF);
    check("after_mid_reset_cout", 32'(Cout), 32'h1);

`ifdef ALU_FLAGS_EN
    step(3'b001, 1'b0, 4'h7, 4'h1);
    check("flag_ovf_g", 32'(G), 32'h8);
    check("flag_ovf_v", 32'(V), 32'h1);
    check("flag_ovf_n", 32'(N), 32'h1);
    check("flag_ovf_z", 32'(Z), 32'h0);
    step(3'b001, 1'b0, 4'hF, 4'h1);
    check("flag_zero_g", 32'(G), 32'h0);
    check("flag_zero_z", 32'(Z), 32'h1);
    check("flag_zero_v", 32'(V), 32'h0);
    step(3'b111, 1'b0, 4'h7, 4'h0);
    check("flag_logic_g", 32'(G), 32'h8);
    check("flag_logic_v", 32'(V), 32'h0);
    check("flag_logic_n", 32'(N), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
Name: alu_4bit

Overview:
- Registered 4-bit arithmetic/logic unit selected by a 3-bit function code (S2,S1,S0) plus carry-in.
- S2=0 selects an arithmetic op through a single adder.
- S2=1 selects a bitwise logic op.
- Result and carry-out are captured into registers on the clock edge, for use as the execute stage of a small datapath.

Parameters:
- WIDTH, 4, operand/result width in bits. All behaviour and tests are stated for 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- S2  input  1  mode select: 0 = arithmetic, 1 = logic
- S1  input  1  function select bit 1
- S0  input  1  function select bit 0
- Cin  input  1  carry-in, arithmetic mode only
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- G  output  WIDTH  registered result
- Cout  output  1  registered carry-out

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset: on a rising edge with rst_n=0, G<=0 and Cout<=0. Reset overrides any operation in progress.
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on G/Cout after edge k. There is no handshake; a new operation is accepted every cycle.
- Arithmetic path (S2=0) computes the (WIDTH+1)-bit sum A + Y + Cin. G is the sum's low WIDTH bits; Cout is the sum's MSB. Y depends on S1S0:
  - 00: Y=0 → transfer A (Cin=0) / increment A (Cin=1)
  - 01: Y=B → A+B / A+B+1
  - 10: Y=~B → A+~B (A−B−1) / A−B (two's complement subtract)
  - 11: Y=all ones → A−1 / transfer A
- Logic path (S2=1); Cin is ignored and Cout is forced to 0:
  - 00: G = A & B
  - 01: G = A | B
  - 10: G = A ^ B
  - 11: G = ~A
- Wrap-around: arithmetic results wrap modulo 2^WIDTH. For example, 1111+0001 gives G=0000, Cout=1.
- Subtraction (S2S1S0=010, Cin=1): Cout=1 means no borrow (A>=B); Cout=0 means borrow.
- Inputs changing between edges have no effect; only values at the edge matter.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, three extra registered outputs are added, all 1 bit, all reset to 0, all with the same 1-cycle latency as G:
  - Z = (next G == 0), valid in both modes.
  - N = next G[WIDTH-1].
  - V = signed overflow of the adder: carry into MSB XOR carry out of MSB. V is forced to 0 in logic mode.
- When undefined, these ports and their logic do not exist, and the port list is exactly as listed above.

Decomposition:
- Package alu_pkg holds:
  - localparam ALU_W = 4
  - function-code constants as a 3-bit typedef {S2,S1,S0}: ARITH_A=000, ARITH_ADD=001, ARITH_SUBB=010, ARITH_DEC=011, LOG_AND=100, LOG_OR=101, LOG_XOR=110, LOG_NOT=111
- One combinational sub-module alu_arith_unit is natural. It takes A, B, S1, S0, Cin and returns the sum, carry-out and (with the flags macro) overflow.
- Logic ops, the result mux, and the output registers live in the top level.

Test Plan:
- Reset: hold rst_n=0 with A=1111, B=0001, S=001 for 2 edges → G=0000, Cout=0. Release rst_n; the first post-reset edge gives G=0000, Cout=1.
- Arithmetic sweep, A=1111, B=0001, S2=0, over all S1S0 and Cin (results listed as G/Cout):
  - S1S0=00: Cin0 → 1111/0; Cin1 → 0000/1
  - S1S0=01: Cin0 → 0000/1; Cin1 → 0001/1
  - S1S0=10: Cin0 → 1101/1; Cin1 → 1110/1
  - S1S0=11: Cin0 → 1110/1; Cin1 → 1111/1
- Logic sweep, A=1111, B=0001, S2=1, Cin both 0 and 1:
  - S1S0=00: G=0001
  - S1S0=01: G=1111
  - S1S0=10: G=1110
  - S1S0=11: G=0000
  - Cout=0 in all cases.
- Subtract borrow: A=0011, B=0101, S=010, Cin=1 → G=1110, Cout=0. Then A=0101, B=0011 → G=0010, Cout=1.
- Latency/back-to-back: change operands every cycle → each result appears exactly one edge after its inputs, with no bubbles. Assert rst_n=0 mid-stream → the next edge gives G=0, Cout=0.
- With ALU_FLAGS_EN: A=0111, B=0001, S=001, Cin=0 → G=1000, V=1, N=1, Z=0. A=1111, B=0001, same op → G=0000, Z=1, V=0.
